uart_tx_fifo: RTL and testbench

- Byte queue and drain sequencer placed directly upstream of the UART transmitter.
- The CPU store path pushes bytes without waiting for the line.
- The block issues queued bytes to the UART one at a time through the UART's write_enable/data/busy handshake.
- It also exposes full, empty, level and overrun status for a memory-mapped status register.

---
 rtl/uart_tx_fifo_if.sv | 40 ++++
 rtl/uart_tx_fifo.sv | 103 ++++++++++
 tb/tb_uart_tx_fifo.sv | 292 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/uart_tx_fifo_if.sv
// CPU-side push port, UART-side handshake and status bundle for uart_tx_fifo.
// drop_count is present only when UART_TX_FIFO_DROP_CNT_EN is defined.
interface uart_tx_fifo_if #(
  parameter int DEPTH = 16
);
  localparam int AW = $clog2(DEPTH);

  logic          push_valid;
  logic [7:0]    push_data;
  logic          push_ready;
  logic          flush;
  logic          uart_write_enable;
  logic [7:0]    uart_data;
  logic          uart_busy;
  logic          full;
  logic          empty;
  logic [AW:0]   level;
  logic          overrun;
`ifdef UART_TX_FIFO_DROP_CNT_EN
  logic [7:0]    drop_count;

  modport master (
    output push_valid, push_data, flush, uart_busy,
    input  push_ready, uart_write_enable, uart_data, full, empty, level, overrun, drop_count
  );
  modport slave (
    input  push_valid, push_data, flush, uart_busy,
    output push_ready, uart_write_enable, uart_data, full, empty, level, overrun, drop_count
  );
`else
  modport master (
    output push_valid, push_data, flush, uart_busy,
    input  push_ready, uart_write_enable, uart_data, full, empty, level, overrun
  );
  modport slave (
    input  push_valid, push_data, flush, uart_busy,
    output push_ready, uart_write_enable, uart_data, full, empty, level, overrun
  );
`endif
endinterface

// File: rtl/uart_tx_fifo.sv
// Byte queue plus drain sequencer feeding a UART transmitter one byte per handshake.
// Optional saturating drop counter enabled by defining UART_TX_FIFO_DROP_CNT_EN.
module uart_tx_fifo #(
  parameter int DEPTH = 16
) (
  input  logic            clk,
  input  logic            rst,
  uart_tx_fifo_if.slave   bus
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT_BUSY, WAIT_DONE} state_t;

  state_t          r_state, w_next;
  logic [7:0]      r_mem [DEPTH];
  logic [AW-1:0]   r_wr_ptr, r_rd_ptr;
  logic [AW:0]     r_count;
  logic            r_overrun;
  logic            r_we;
  logic [7:0]      r_data;
  logic [1:0]      r_guard;

  logic            w_full, w_empty, w_push, w_pop, w_drop;

  assign w_full  = (r_count == FULL_CNT);
  assign w_empty = (r_count == '0);
  // Flush discards a same-cycle push; full is judged on the pre-edge count.
  assign w_push  = bus.push_valid && !w_full && !bus.flush;
  assign w_drop  = bus.push_valid && w_full;
  assign w_pop   = (r_state == IDLE) && !w_empty && !bus.uart_busy;

  always_comb begin
    // NOTE: default first so no path through the case leaves w_next unassigned (no latch).
    w_next = r_state;
    unique case (r_state)
      IDLE:      if (w_pop) w_next = ISSUE;
      ISSUE:     w_next = WAIT_BUSY;
      WAIT_BUSY: begin
        if (bus.uart_busy)        w_next = WAIT_DONE;
        else if (r_guard == 2'd3) w_next = IDLE;
      end
      WAIT_DONE: if (!bus.uart_busy) w_next = IDLE;
      default:   w_next = IDLE;
    endcase
  end

  // NOTE: the storage array has no reset; pointers and count define which entries are valid.
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= bus.push_data;
  end

  // NOTE: all sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= IDLE;
      r_we      <= 1'b0;
      r_data    <= 8'h00;
      r_guard   <= 2'd0;
      r_wr_ptr  <= '0;
      r_rd_ptr  <= '0;
      r_count   <= '0;
      r_overrun <= 1'b0;
    end else begin
      r_state <= w_next;
      r_we    <= (w_next == ISSUE);
      // Counts consecutive idle-busy cycles after a strobe; a lost strobe is not retried.
      r_guard <= (r_state == WAIT_BUSY && !bus.uart_busy) ? r_guard + 2'd1 : 2'd0;
      if (w_pop) r_data <= r_mem[r_rd_ptr];
      if (bus.flush) begin
        r_wr_ptr  <= '0;
        r_rd_ptr  <= '0;
        r_count   <= '0;
        r_overrun <= 1'b0;
      end else begin
        if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
        if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
        if (w_push && !w_pop)      r_count <= r_count + (AW+1)'(1);
        else if (!w_push && w_pop) r_count <= r_count - (AW+1)'(1);
        if (w_drop) r_overrun <= 1'b1;
      end
    end
  end

`ifdef UART_TX_FIFO_DROP_CNT_EN
  logic [7:0] r_drop_cnt;

  always_ff @(posedge clk) begin
    if (rst || bus.flush)                 r_drop_cnt <= 8'h00;
    else if (w_drop && r_drop_cnt != 8'hFF) r_drop_cnt <= r_drop_cnt + 8'h01;
  end

  assign bus.drop_count = r_drop_cnt;
`endif

  assign bus.push_ready        = !w_full;
  assign bus.full              = w_full;
  assign bus.empty             = w_empty;
  assign bus.level             = r_count;
  assign bus.overrun           = r_overrun;
  assign bus.uart_write_enable = r_we;
  assign bus.uart_data         = r_data;
endmodule

// File: tb/tb_uart_tx_fifo.sv
// Directed bench for uart_tx_fifo: fill/overrun table, drain order, wrap,
// flush in flight, lost-strobe guard and mid-transfer reset.
module tb_uart_tx_fifo;
  localparam int DEPTH = 16;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  uart_tx_fifo_if #(.DEPTH(DEPTH)) bus();
  uart_tx_fifo #(.DEPTH(DEPTH)) dut (.clk(clk), .rst(rst), .bus(bus));

  int checks   = 0;
  int failures = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic timeout_fail(input string name);
    checks++;
    failures++;
    $display("FAIL %s actual=timeout expected=event", name);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Simple UART model: busy for 3 cycles starting just after the sampling edge.
  logic busy_force = 1'b0;
  logic model_busy = 1'b0;
  logic model_en   = 1'b0;
  assign bus.uart_busy = busy_force | model_busy;

  int cyc = 0;
  always @(posedge clk) cyc++;

  logic [7:0] rx_q[$];
  int         strobe_cyc[$];
  int         strobe_cnt = 0;
  logic       prev_we = 1'b0;

  initial forever begin
    @(negedge clk);
    if (bus.uart_write_enable === 1'b1) begin
      strobe_cnt++;
      rx_q.push_back(bus.uart_data);
      strobe_cyc.push_back(cyc);
      check("we_not_consecutive", 32'(prev_we), 32'd0);
    end
    prev_we = bus.uart_write_enable;
  end

  initial forever begin
    @(negedge clk);
    if (model_en && bus.uart_write_enable === 1'b1) begin
      @(posedge clk);
      #1 model_busy = 1'b1;
      repeat (3) @(posedge clk);
      #1 model_busy = 1'b0;
    end
  end

  typedef struct {
    logic       pv;
    logic [7:0] pd;
    logic [4:0] lvl;
    logic       full;
    logic       empty;
    logic       ready;
    logic       ovr;
  } vec_t;

  vec_t       vecs[18];
  logic [7:0] exp_q[$];

  initial begin
    #200000;
    $display("FAIL global_timeout actual=running expected=finished");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
    $fatal(1, "timeout");
  end

  initial begin
    int s0;
    int w;

    bus.push_valid = 1'b0;
    bus.push_data  = 8'h00;
    bus.flush      = 1'b0;
    rst            = 1'b1;
    repeat (2) tick();
    rst = 1'b0;

    // Reset values
    check("rst_we",    32'(bus.uart_write_enable), 32'd0);
    check("rst_data",  32'(bus.uart_data), 32'h00);
    check("rst_full",  32'(bus.full), 32'd0);
    check("rst_empty", 32'(bus.empty), 32'd1);
    check("rst_level", 32'(bus.level), 32'd0);
    check("rst_ovr",   32'(bus.overrun), 32'd0);
    check("rst_ready", 32'(bus.push_ready), 32'd1);
`ifdef UART_TX_FIFO_DROP_CNT_EN
    check("rst_drop",  32'(bus.drop_count), 32'd0);
`endif

    // Single byte latency: push at t0, strobe in the cycle after t1
    model_en = 1'b1;
    s0 = strobe_cnt;
    bus.push_valid = 1'b1;
    bus.push_data  = 8'h41;
    tick();
    bus.push_valid = 1'b0;
    check("t0_we",     32'(bus.uart_write_enable), 32'd0);
    check("t0_level",  32'(bus.level), 32'd1);
    tick();
    check("t1_we",     32'(bus.uart_write_enable), 32'd1);
    check("t1_data",   32'(bus.uart_data), 32'h41);
    check("t1_level",  32'(bus.level), 32'd0);
    check("t1_empty",  32'(bus.empty), 32'd1);
    tick();
    check("t2_we",     32'(bus.uart_write_enable), 32'd0);
    repeat (8) tick();
    check("single_strobes", 32'(strobe_cnt - s0), 32'd1);

    // Fill to full with UART busy, then two dropped pushes
    for (int i = 0; i < 16; i++)
      vecs[i] = '{pv: 1'b1, pd: 8'(i + 1), lvl: 5'(i + 1), full: (i == 15),
                  empty: 1'b0, ready: (i != 15), ovr: 1'b0};
    for (int i = 16; i < 18; i++)
      vecs[i] = '{pv: 1'b1, pd: 8'hEE, lvl: 5'd16, full: 1'b1,
                  empty: 1'b0, ready: 1'b0, ovr: 1'b1};

    busy_force = 1'b1;
    rx_q.delete();
    s0 = strobe_cnt;
    for (int i = 0; i < 18; i++) begin
      bus.push_valid = vecs[i].pv;
      bus.push_data  = vecs[i].pd;
      tick();
      bus.push_valid = 1'b0;
      check($sformatf("vec%0d_level", i), 32'(bus.level), 32'(vecs[i].lvl));
      check($sformatf("vec%0d_full", i),  32'(bus.full), 32'(vecs[i].full));
      check($sformatf("vec%0d_empty", i), 32'(bus.empty), 32'(vecs[i].empty));
      check($sformatf("vec%0d_ready", i), 32'(bus.push_ready), 32'(vecs[i].ready));
      check($sformatf("vec%0d_ovr", i),   32'(bus.overrun), 32'(vecs[i].ovr));
    end
    check("full_no_strobe", 32'(strobe_cnt - s0), 32'd0);
    check("full_data_held", 32'(bus.uart_data), 32'h41);
`ifdef UART_TX_FIFO_DROP_CNT_EN
    check("drop_count_2", 32'(bus.drop_count), 32'd2);
`endif

    // Drain: bytes come out in order, no 0xEE
    busy_force = 1'b0;
    w = 0;
    while (rx_q.size() < 16 && w < 2000) begin tick(); w++; end
    if (w >= 2000) timeout_fail("drain_wait");
    repeat (8) tick();
    check("drain_count", 32'(rx_q.size()), 32'd16);
    for (int i = 0; i < 16; i++)
      if (i < rx_q.size()) check($sformatf("drain_byte%0d", i), 32'(rx_q[i]), 32'(i + 1));
    check("drain_level", 32'(bus.level), 32'd0);
    check("drain_empty", 32'(bus.empty), 32'd1);
    check("drain_ovr_sticky", 32'(bus.overrun), 32'd1);

    // Flush with a concurrent push: push discarded, overrun cleared
    s0 = strobe_cnt;
    bus.flush      = 1'b1;
    bus.push_valid = 1'b1;
    bus.push_data  = 8'h99;
    tick();
    bus.flush      = 1'b0;
    bus.push_valid = 1'b0;
    check("flush_level", 32'(bus.level), 32'd0);
    check("flush_ovr",   32'(bus.overrun), 32'd0);
    check("flush_empty", 32'(bus.empty), 32'd1);
`ifdef UART_TX_FIFO_DROP_CNT_EN
    check("flush_drop",  32'(bus.drop_count), 32'd0);
`endif
    repeat (6) tick();
    check("flush_no_strobe", 32'(strobe_cnt - s0), 32'd0);

    // Push and pop in one cycle at level 5, then wrap the pointers
    rx_q.delete();
    exp_q.delete();
    busy_force = 1'b1;
    for (int i = 0; i < 5; i++) begin
      bus.push_valid = 1'b1;
      bus.push_data  = 8'(8'hA0 + i);
      exp_q.push_back(8'(8'hA0 + i));
      tick();
    end
    bus.push_valid = 1'b0;
    check("lvl5_pre", 32'(bus.level), 32'd5);
    busy_force     = 1'b0;
    bus.push_valid = 1'b1;
    bus.push_data  = 8'hA5;
    exp_q.push_back(8'hA5);
    tick();
    bus.push_valid = 1'b0;
    check("lvl5_pushpop_level", 32'(bus.level), 32'd5);
    check("lvl5_pushpop_we",    32'(bus.uart_write_enable), 32'd1);

    for (int n = 0; n < 40; n++) begin
      w = 0;
      while (bus.push_ready !== 1'b1 && w < 500) begin tick(); w++; end
      if (w >= 500) timeout_fail("wrap_ready_wait");
      bus.push_valid = 1'b1;
      bus.push_data  = 8'(n * 7 + 3);
      exp_q.push_back(8'(n * 7 + 3));
      tick();
      bus.push_valid = 1'b0;
    end
    w = 0;
    while (rx_q.size() < exp_q.size() && w < 5000) begin tick(); w++; end
    if (w >= 5000) timeout_fail("wrap_drain_wait");
    repeat (8) tick();
    check("wrap_count", 32'(rx_q.size()), 32'(exp_q.size()));
    for (int i = 0; i < exp_q.size(); i++)
      if (i < rx_q.size()) check($sformatf("wrap_byte%0d", i), 32'(rx_q[i]), 32'(exp_q[i]));
    check("wrap_level", 32'(bus.level), 32'd0);

    // Flush while a byte is in WAIT_DONE with three queued
    rx_q.delete();
    s0 = strobe_cnt;
    for (int i = 0; i < 4; i++) begin
      bus.push_valid = 1'b1;
      bus.push_data  = 8'(8'hB0 + i);
      tick();
    end
    bus.push_valid = 1'b0;
    busy_force = 1'b1;
    repeat (2) tick();
    check("inflight_level", 32'(bus.level), 32'd3);
    bus.flush = 1'b1;
    tick();
    bus.flush = 1'b0;
    check("inflight_flush_level", 32'(bus.level), 32'd0);
    check("inflight_flush_empty", 32'(bus.empty), 32'd1);
    busy_force = 1'b0;
    repeat (30) tick();
    check("inflight_strobes", 32'(strobe_cnt - s0), 32'd1);
    if (rx_q.size() > 0) check("inflight_byte", 32'(rx_q[0]), 32'hB0);

    // Lost strobe: busy never rises, guard returns to IDLE after 4 cycles
    model_en = 1'b0;
    rx_q.delete();
    strobe_cyc.delete();
    s0 = strobe_cnt;
    bus.push_valid = 1'b1;
    bus.push_data  = 8'hC0;
    tick();
    bus.push_data  = 8'hC1;
    tick();
    bus.push_valid = 1'b0;
    repeat (20) tick();
    check("lost_strobes", 32'(strobe_cnt - s0), 32'd2);
    if (strobe_cyc.size() == 2) begin
      check("lost_gap",   32'(strobe_cyc[1] - strobe_cyc[0]), 32'd6);
      check("lost_byte0", 32'(rx_q[0]), 32'hC0);
      check("lost_byte1", 32'(rx_q[1]), 32'hC1);
    end

    // Reset mid-activity returns everything to reset values
    busy_force = 1'b1;
    bus.push_valid = 1'b1;
    bus.push_data  = 8'hD0;
    tick();
    tick();
    bus.push_valid = 1'b0;
    check("prerst_level", 32'(bus.level), 32'd2);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("midrst_level", 32'(bus.level), 32'd0);
    check("midrst_data",  32'(bus.uart_data), 32'h00);
    check("midrst_ready", 32'(bus.push_ready), 32'd1);
    check("midrst_we",    32'(bus.uart_write_enable), 32'd0);
    busy_force = 1'b0;
    repeat (3) tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
